// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings for the load/store unit.
//   - MemOp codes (same encoding the control unit drives on mem_op)
//   - Controller state codes
//   - size_of(): access size in bytes for a MemOp code (0 for illegal codes)
//   - op_legal(): 1 for the five defined MemOp codes
package lsu_pkg;

    localparam logic [2:0] MOP_B  = 3'b000;
    localparam logic [2:0] MOP_BU = 3'b001;
    localparam logic [2:0] MOP_H  = 3'b010;
    localparam logic [2:0] MOP_HU = 3'b011;
    localparam logic [2:0] MOP_W  = 3'b100;

    // ST_GAP is the idle cycle between the two beats of a split access,
    // which guarantees bus_req drops before the second beat starts.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BEAT0 = 3'd1,
        ST_GAP   = 3'd2,
        ST_BEAT1 = 3'd3,
        ST_DONE  = 3'd4
    } lsu_state_e;

    function automatic logic [2:0] size_of(input logic [2:0] op);
        case (op)
            MOP_B, MOP_BU: size_of = 3'd1;
            MOP_H, MOP_HU: size_of = 3'd2;
            MOP_W:         size_of = 3'd4;
            default:       size_of = 3'd0;
        endcase
    endfunction

    function automatic logic op_legal(input logic [2:0] op);
        op_legal = (op <= MOP_W);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane logic for the load/store unit.
//   off     in  2   byte offset within the first word
//   mem_op  in  3   MemOp code (selects size and extension)
//   wdata   in  32  right-justified store data
//   beat0   in  32  word read by the first beat
//   beat1   in  32  word read by the second beat (ignored when not split)
//   mask    out 8   byte-lane mask across two words (low nibble = beat0)
//   sdata   out 64  lane-shifted store data, disabled lanes forced to 0
//   ldata   out 32  shifted and sign/zero-extended load result
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [2:0]  mem_op,
    input  logic [31:0] wdata,
    input  logic [31:0] beat0,
    input  logic [31:0] beat1,
    output logic [7:0]  mask,
    output logic [63:0] sdata,
    output logic [31:0] ldata
);

    logic [7:0]  base;
    logic [63:0] shifted;
    logic [31:0] r;

    // NOTE: every signal assigned in always_comb gets a value on every path
    // (default first), otherwise synthesis infers a latch.
    always_comb begin
        base    = (8'd1 << size_of(mem_op)) - 8'd1;
        mask    = base << off;
        shifted = {32'b0, wdata} << {off, 3'b000};
        sdata   = '0;
        for (int i = 0; i < 8; i++) begin
            if (mask[i]) sdata[8*i +: 8] = shifted[8*i +: 8];
        end

        // Bring the addressed byte down to lane 0, keeping only 32 bits.
        r = 32'({beat1, beat0} >> {off, 3'b000});
        case (mem_op)
            MOP_B:   ldata = {{24{r[7]}}, r[7:0]};
            MOP_BU:  ldata = {24'b0, r[7:0]};
            MOP_H:   ldata = {{16{r[15]}}, r[15:0]};
            MOP_HU:  ldata = {16'b0, r[15:0]};
            default: ldata = r;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: executes one load or store against word-aligned data memory
// over a single-outstanding req/ack bus; misaligned accesses become two beats.
//   clk, rst_n          clock, asynchronous active-low reset
//   start               request strobe, accepted only in IDLE
//   mem_wr/mem_op       1=store / access type (see lsu_pkg)
//   addr, wdata         byte address and right-justified store data
//   busy                request in flight
//   done, err           one-cycle completion pulse, error flag valid with done
//   rdata               extended load data, held until the next load completes
//   bus_req/we/addr/be/wdata  beat request toward memory
//   bus_ack, bus_rdata  beat completion and read word (same cycle)
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int WAIT_LIMIT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mem_wr,
    input  logic [2:0]        mem_op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata
);

    lsu_state_e        state_q, state_d;
    logic              wr_q;
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       beat0_q, beat1_q;
    logic [7:0]        cnt_q;
    logic              err_q;
    logic [31:0]       rdata_q;

    logic              abort;
    logic              split;
    logic              ack;
    logic              timeout;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [7:0]        mask;
    logic [63:0]       sdata;
    logic [31:0]       ldata;
    logic [31:0]       beat0_in, beat1_in;

    assign split   = ({2'b0, addr_q[1:0]} + {1'b0, size_of(op_q)}) > 4'd4;
    assign ack     = bus_req & bus_ack;
    assign timeout = bus_req & ~bus_ack & (cnt_q == 8'(WAIT_LIMIT - 1));
    assign addr0   = {addr_q[ADDR_W-1:2], 2'b00};
    assign addr1   = addr0 + ADDR_W'(4);

    // The word arriving this cycle is fed straight in so the load result is
    // ready in the same cycle the final ack arrives.
    assign beat0_in = (state_q == ST_BEAT0) ? bus_rdata : beat0_q;
    assign beat1_in = (state_q == ST_BEAT1) ? bus_rdata : beat1_q;

    lsu_align u_align (
        .off    (addr_q[1:0]),
        .mem_op (op_q),
        .wdata  (wdata_q),
        .beat0  (beat0_in),
        .beat1  (beat1_in),
        .mask   (mask),
        .sdata  (sdata),
        .ldata  (ldata)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        abort   = 1'b0;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_BEAT0;
            ST_BEAT0: begin
                // Illegal codes spend one cycle here with no bus activity.
                if (!op_legal(op_q)) begin
                    state_d = ST_DONE;
                    abort   = 1'b1;
                end else if (ack) begin
                    state_d = split ? ST_GAP : ST_DONE;
                end else if (timeout) begin
                    state_d = ST_DONE;
                    abort   = 1'b1;
                end
            end
            ST_GAP: state_d = ST_BEAT1;
            ST_BEAT1: begin
                if (ack) begin
                    state_d = ST_DONE;
                end else if (timeout) begin
                    state_d = ST_DONE;
                    abort   = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q == ST_BEAT0) || (state_q == ST_GAP) || (state_q == ST_BEAT1);
        done      = (state_q == ST_DONE);
        err       = done & err_q;
        rdata     = rdata_q;
        bus_req   = ((state_q == ST_BEAT0) && op_legal(op_q)) || (state_q == ST_BEAT1);
        bus_we    = 1'b0;
        bus_addr  = '0;
        bus_be    = '0;
        bus_wdata = '0;
        if (bus_req) begin
            bus_we = wr_q;
            if (state_q == ST_BEAT1) begin
                bus_addr  = addr1;
                bus_be    = mask[7:4];
                bus_wdata = sdata[63:32];
            end else begin
                bus_addr  = addr0;
                bus_be    = mask[3:0];
                bus_wdata = sdata[31:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= 1'b0;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            beat0_q <= '0;
            beat1_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (state_q == ST_IDLE && start) begin
                wr_q    <= mem_wr;
                op_q    <= mem_op;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            // Counts unacknowledged request cycles; any other cycle clears it,
            // so it restarts from 0 on entry to each beat.
            if (bus_req && !bus_ack) cnt_q <= cnt_q + 8'd1;
            else                     cnt_q <= '0;
            if (ack && state_q == ST_BEAT0) beat0_q <= bus_rdata;
            if (ack && state_q == ST_BEAT1) beat1_q <= bus_rdata;
            if (state_d == ST_DONE && state_q != ST_DONE) err_q <= abort;
            // Only a load whose final beat was acknowledged updates rdata.
            if (ack && state_d == ST_DONE && !wr_q) rdata_q <= ldata;
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: directed tests for lsu_mem_ctrl with hand-computed values.
// Inputs are driven and outputs sampled on the falling edge; the DUT acts on
// the rising edge. Cycle 0 is the cycle in which start is held high.
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        mem_wr = 1'b0;
    logic [2:0]  mem_op = 3'b000;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        busy, done, err;
    logic [31:0] rdata;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;

    int tests_run = 0;
    int tests_failed = 0;

    // Results of the most recent do_access call.
    int          nbeats, req_cycles, done_cyc;
    logic        o_err, busy_at1, busy_at_done;
    logic [31:0] o_rdata;
    logic [31:0] b_addr [2];
    logic [3:0]  b_be   [2];
    logic [31:0] b_wd   [2];
    logic        b_we   [2];

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.ADDR_W(32), .WAIT_LIMIT(255)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mem_wr    (mem_wr),
        .mem_op    (mem_op),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata)
    );

    // Issues one request and plays the memory side: every request cycle is
    // acknowledged immediately (rd0 for the first beat, rd1 for the second)
    // unless never_ack is set. Gives up after 400 cycles (done_cyc stays -1).
    task automatic do_access(input logic wr, input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] rd0,
                             input logic [31:0] rd1, input bit never_ack);
        @(negedge clk);
        mem_wr = wr; mem_op = op; addr = a; wdata = wd; start = 1'b1;
        nbeats = 0; req_cycles = 0; done_cyc = -1;
        o_err = 1'bx; o_rdata = 'x; busy_at1 = 1'bx; busy_at_done = 1'bx;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clk);
            start = 1'b0; bus_ack = 1'b0;
            if (cyc == 1) busy_at1 = busy;
            if (done) begin
                done_cyc = cyc; o_err = err; o_rdata = rdata; busy_at_done = busy;
                break;
            end
            if (bus_req) begin
                req_cycles++;
                if (!never_ack) begin
                    if (nbeats < 2) begin
                        b_addr[nbeats] = bus_addr; b_be[nbeats] = bus_be;
                        b_wd[nbeats] = bus_wdata; b_we[nbeats] = bus_we;
                        bus_rdata = (nbeats == 0) ? rd0 : rd1;
                    end
                    bus_ack = 1'b1;
                    nbeats++;
                end
            end
        end
        bus_ack = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({busy, done, err, bus_req, bus_we} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b expected 00000", {busy, done, err, bus_req, bus_we});
        end
        tests_run++;
        if ({rdata, bus_addr, bus_be, bus_wdata} !== 100'b0) begin
            tests_failed++;
            $display("FAIL reset_data: got rdata=%h addr=%h be=%b wd=%h expected all 0",
                     rdata, bus_addr, bus_be, bus_wdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_aligned_lw;
        do_access(1'b0, 3'b100, 32'h100, 32'h0, 32'hDEADBEEF, 32'h0, 1'b0);
        tests_run++;
        if (done_cyc !== 2 || nbeats !== 1) begin
            tests_failed++;
            $display("FAIL lw_latency: got done_cyc=%0d beats=%0d expected 2/1", done_cyc, nbeats);
        end
        tests_run++;
        if ({b_addr[0], b_be[0], b_we[0]} !== {32'h100, 4'b1111, 1'b0}) begin
            tests_failed++;
            $display("FAIL lw_beat: got addr=%h be=%b we=%b expected 00000100/1111/0",
                     b_addr[0], b_be[0], b_we[0]);
        end
        tests_run++;
        if ({o_rdata, o_err} !== {32'hDEADBEEF, 1'b0}) begin
            tests_failed++;
            $display("FAIL lw_result: got rdata=%h err=%b expected deadbeef/0", o_rdata, o_err);
        end
        tests_run++;
        if ({busy_at1, busy_at_done} !== 2'b10) begin
            tests_failed++;
            $display("FAIL lw_busy: got at1=%b at_done=%b expected 1/0", busy_at1, busy_at_done);
        end
    endtask

    task automatic test_byte_loads;
        do_access(1'b0, 3'b000, 32'h203, 32'h0, 32'h80FFFFFF, 32'h0, 1'b0);
        tests_run++;
        if ({b_addr[0], b_be[0], o_rdata, o_err} !== {32'h200, 4'b1000, 32'hFFFFFF80, 1'b0}) begin
            tests_failed++;
            $display("FAIL lb: got addr=%h be=%b rdata=%h err=%b expected 00000200/1000/ffffff80/0",
                     b_addr[0], b_be[0], o_rdata, o_err);
        end
        do_access(1'b0, 3'b001, 32'h203, 32'h0, 32'h80FFFFFF, 32'h0, 1'b0);
        tests_run++;
        if ({o_rdata, done_cyc} !== {32'h00000080, 32'd2}) begin
            tests_failed++;
            $display("FAIL lbu: got rdata=%h done_cyc=%0d expected 00000080/2", o_rdata, done_cyc);
        end
    endtask

    task automatic test_half_load;
        do_access(1'b0, 3'b011, 32'h12, 32'h0, 32'h80017FFF, 32'h0, 1'b0);
        tests_run++;
        if ({b_addr[0], b_be[0], o_rdata} !== {32'h10, 4'b1100, 32'h00008001}) begin
            tests_failed++;
            $display("FAIL lhu: got addr=%h be=%b rdata=%h expected 00000010/1100/00008001",
                     b_addr[0], b_be[0], o_rdata);
        end
    endtask

    task automatic test_byte_store;
        do_access(1'b1, 3'b000, 32'h301, 32'h123456AA, 32'hFFFFFFFF, 32'h0, 1'b0);
        tests_run++;
        if ({b_addr[0], b_be[0], b_wd[0], b_we[0]} !== {32'h300, 4'b0010, 32'h0000AA00, 1'b1}) begin
            tests_failed++;
            $display("FAIL sb_beat: got addr=%h be=%b wd=%h we=%b expected 00000300/0010/0000aa00/1",
                     b_addr[0], b_be[0], b_wd[0], b_we[0]);
        end
        tests_run++;
        if ({o_rdata, o_err, done_cyc} !== {32'h00008001, 1'b0, 32'd2}) begin
            tests_failed++;
            $display("FAIL sb_done: got rdata=%h err=%b done_cyc=%0d expected 00008001/0/2",
                     o_rdata, o_err, done_cyc);
        end
    endtask

    task automatic test_split_store;
        do_access(1'b1, 3'b100, 32'h0FE, 32'h11223344, 32'h0, 32'h0, 1'b0);
        tests_run++;
        if (nbeats !== 2 || req_cycles !== 2 || done_cyc !== 4) begin
            tests_failed++;
            $display("FAIL sw_split_timing: got beats=%0d req=%0d done_cyc=%0d expected 2/2/4",
                     nbeats, req_cycles, done_cyc);
        end
        tests_run++;
        if ({b_addr[0], b_be[0], b_wd[0]} !== {32'h0FC, 4'b1100, 32'h33440000}) begin
            tests_failed++;
            $display("FAIL sw_beat0: got addr=%h be=%b wd=%h expected 000000fc/1100/33440000",
                     b_addr[0], b_be[0], b_wd[0]);
        end
        tests_run++;
        if ({b_addr[1], b_be[1], b_wd[1], b_we[1]} !== {32'h100, 4'b0011, 32'h00001122, 1'b1}) begin
            tests_failed++;
            $display("FAIL sw_beat1: got addr=%h be=%b wd=%h we=%b expected 00000100/0011/00001122/1",
                     b_addr[1], b_be[1], b_wd[1], b_we[1]);
        end
        tests_run++;
        if ({o_rdata, o_err} !== {32'h00008001, 1'b0}) begin
            tests_failed++;
            $display("FAIL sw_done: got rdata=%h err=%b expected 00008001/0", o_rdata, o_err);
        end
    endtask

    task automatic test_split_load;
        do_access(1'b0, 3'b010, 32'h7, 32'h0, 32'hAB000000, 32'h000000CD, 1'b0);
        tests_run++;
        if ({b_addr[0], b_be[0], b_addr[1], b_be[1]} !== {32'h4, 4'b1000, 32'h8, 4'b0001}) begin
            tests_failed++;
            $display("FAIL lh_split_beats: got %h/%b %h/%b expected 00000004/1000 00000008/0001",
                     b_addr[0], b_be[0], b_addr[1], b_be[1]);
        end
        tests_run++;
        if ({o_rdata, o_err, done_cyc} !== {32'hFFFFCDAB, 1'b0, 32'd4}) begin
            tests_failed++;
            $display("FAIL lh_split_result: got rdata=%h err=%b done_cyc=%0d expected ffffcdab/0/4",
                     o_rdata, o_err, done_cyc);
        end
        // Second beat wraps from the top of the address space to 0.
        do_access(1'b0, 3'b010, 32'hFFFFFFFF, 32'h0, 32'h12000000, 32'h00000034, 1'b0);
        tests_run++;
        if ({b_addr[0], b_addr[1], o_rdata} !== {32'hFFFFFFFC, 32'h0, 32'h00003412}) begin
            tests_failed++;
            $display("FAIL lh_wrap: got a0=%h a1=%h rdata=%h expected fffffffc/00000000/00003412",
                     b_addr[0], b_addr[1], o_rdata);
        end
    endtask

    task automatic test_illegal;
        do_access(1'b0, 3'b110, 32'h40, 32'h0, 32'h55555555, 32'h0, 1'b0);
        tests_run++;
        if (req_cycles !== 0 || done_cyc !== 2) begin
            tests_failed++;
            $display("FAIL illegal_timing: got req=%0d done_cyc=%0d expected 0/2", req_cycles, done_cyc);
        end
        tests_run++;
        if ({o_err, o_rdata} !== {1'b1, 32'h00003412}) begin
            tests_failed++;
            $display("FAIL illegal_result: got err=%b rdata=%h expected 1/00003412", o_err, o_rdata);
        end
    endtask

    task automatic test_timeout;
        do_access(1'b0, 3'b100, 32'h40, 32'h0, 32'h0, 32'h0, 1'b1);
        tests_run++;
        if (req_cycles !== 255 || done_cyc !== 256) begin
            tests_failed++;
            $display("FAIL timeout_timing: got req=%0d done_cyc=%0d expected 255/256",
                     req_cycles, done_cyc);
        end
        tests_run++;
        if ({o_err, o_rdata} !== {1'b1, 32'h00003412}) begin
            tests_failed++;
            $display("FAIL timeout_result: got err=%b rdata=%h expected 1/00003412", o_err, o_rdata);
        end
    endtask

    task automatic test_back_to_back;
        do_access(1'b0, 3'b100, 32'h20, 32'h0, 32'hCAFEF00D, 32'h0, 1'b0);
        tests_run++;
        if ({o_rdata, done_cyc} !== {32'hCAFEF00D, 32'd2}) begin
            tests_failed++;
            $display("FAIL b2b_first: got rdata=%h done_cyc=%0d expected cafef00d/2", o_rdata, done_cyc);
        end
        // Still in the done cycle: this start must be ignored.
        addr = 32'h24; mem_op = 3'b100; mem_wr = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({busy, bus_req, done} !== 3'b000) begin
            tests_failed++;
            $display("FAIL start_in_done: got busy/req/done=%b expected 000", {busy, bus_req, done});
        end
    endtask

    task automatic test_reset_mid;
        bit saw_done = 0;
        @(negedge clk);
        mem_wr = 1'b1; mem_op = 3'b100; addr = 32'h0FE; wdata = 32'h11223344; start = 1'b1;
        @(negedge clk);                     // cycle 1: beat0
        start = 1'b0; bus_ack = bus_req;
        @(negedge clk);                     // cycle 2: gap
        bus_ack = 1'b0;
        @(negedge clk);                     // cycle 3: beat1
        tests_run++;
        if (bus_req !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_mid_setup: got bus_req=%b expected 1 in beat1", bus_req);
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({bus_req, busy} !== 2'b00) begin
            tests_failed++;
            $display("FAIL rst_mid_async: got req/busy=%b expected 00", {bus_req, busy});
        end
        repeat (3) begin
            @(negedge clk);
            if (done) saw_done = 1;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done) saw_done = 1;
        end
        tests_run++;
        if (saw_done !== 1'b0 || rdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL rst_mid_no_done: got saw_done=%b rdata=%h expected 0/00000000", saw_done, rdata);
        end
        do_access(1'b0, 3'b100, 32'h100, 32'h0, 32'h5A5A1234, 32'h0, 1'b0);
        tests_run++;
        if ({o_rdata, o_err, done_cyc} !== {32'h5A5A1234, 1'b0, 32'd2}) begin
            tests_failed++;
            $display("FAIL rst_mid_recover: got rdata=%h err=%b done_cyc=%0d expected 5a5a1234/0/2",
                     o_rdata, o_err, done_cyc);
        end
    endtask

    initial begin
        test_reset();
        test_aligned_lw();
        test_byte_loads();
        test_half_load();
        test_byte_store();
        test_split_store();
        test_split_load();
        test_illegal();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
